// File: rtl/bsg_clk_downsample_multi.sv
// num_ch_p programmable clock dividers with double-buffered divide values; no backpressure.
// A disabled channel takes a new config the next cycle. A running channel takes it at its falling-edge terminal count. Optional BSG_CLK_DOWNSAMPLE_MULTI_EDGE_CNT_EN adds edge counters.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_clk_downsample_multi #(
   parameter int num_ch_p = 4,
   parameter int width_p  = 8,
   parameter int lg_ch_lp = `BSG_SAFE_CLOG2(num_ch_p)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cfg_v_i,
   input  logic [lg_ch_lp-1:0]   cfg_ch_i,
   input  logic                  cfg_en_i,
   input  logic [width_p-1:0]    cfg_val_i,
   input  logic                  sync_i,
   output logic [num_ch_p-1:0]   pending_o,
   output logic [num_ch_p-1:0]   en_o,
   output logic [num_ch_p-1:0]   clk_r_o
`ifdef BSG_CLK_DOWNSAMPLE_MULTI_EDGE_CNT_EN
  ,output logic [num_ch_p*16-1:0] edge_cnt_o
`endif
);

   for (genvar g = 0; g < num_ch_p; g++) begin : g_ch
      logic [width_p-1:0] r_ctr, r_val, r_val_s;
      logic               r_en, r_en_s, r_clk, r_pend;
      logic               w_wr, w_tc, w_apply, w_en_nxt, w_rise;
      logic [width_p-1:0] w_val_nxt;

      assign w_wr = cfg_v_i && (cfg_ch_i == lg_ch_lp'(g));
      assign w_tc = (r_ctr == r_val);

      // Sync folds a same-cycle write straight into the applied config.
      assign w_apply   = sync_i ? (r_pend | w_wr)
                                : (r_pend & (~r_en | (w_tc & r_clk)));
      assign w_en_nxt  = (sync_i && w_wr) ? cfg_en_i  : r_en_s;
      assign w_val_nxt = (sync_i && w_wr) ? cfg_val_i : r_val_s;
      assign w_rise    = r_en & ~w_apply & ~sync_i & w_tc & ~r_clk;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            r_ctr   <= '0;
            r_val   <= '0;
            r_val_s <= '0;
            r_en    <= 1'b0;
            r_en_s  <= 1'b0;
            r_clk   <= 1'b0;
            r_pend  <= 1'b0;
         end else begin
            if (w_wr) begin
               r_en_s  <= cfg_en_i;
               r_val_s <= cfg_val_i;
            end
            if (w_apply) begin
               r_en  <= w_en_nxt;
               r_val <= w_val_nxt;
            end
            if (sync_i || w_apply || !r_en) begin
               r_ctr <= '0;
               r_clk <= 1'b0;
            end else if (w_tc) begin
               r_ctr <= '0;
               r_clk <= ~r_clk;
            end else begin
               r_ctr <= r_ctr + 1'b1;
            end
            r_pend <= w_wr ? ~sync_i : (r_pend & ~w_apply);
         end
      end

      assign pending_o[g] = r_pend;
      assign en_o[g]      = r_en;
      assign clk_r_o[g]   = r_clk;

`ifdef BSG_CLK_DOWNSAMPLE_MULTI_EDGE_CNT_EN
      logic [15:0] r_ecnt;
      always_ff @(posedge clk_i) begin
         if (reset_i || sync_i) begin
            r_ecnt <= '0;
         end else if (w_rise) begin
            r_ecnt <= r_ecnt + 16'd1;
         end
      end
      assign edge_cnt_o[g*16 +: 16] = r_ecnt;
`else
      logic w_rise_unused;
      assign w_rise_unused = w_rise;
`endif
   end

endmodule
